iddmm_mul_pipe: RTL and testbench

// - Parametrised, fully pipelined unsigned W x W -> 2W multiplier for the

---
 rtl/iddmm_mul_pipe_if.sv | 27 ++
 rtl/iddmm_mul_pipe.sv | 97 +++++++++
 tb/tb_iddmm_mul_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iddmm_mul_pipe_if.sv
// Handshake bundle for the IDDMM multiplier: operations in, tagged products out.
interface iddmm_mul_pipe_if #(
    parameter int W     = 128,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [1:0]       mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, x, y, mode, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );

    modport slave (
        input  in_valid, x, y, mode, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

// File: rtl/iddmm_mul_pipe.sv
// Pipelined W x W -> 2W unsigned multiplier with valid/ready stall, tag passthrough,
// low-half and squaring modes. Stages: operand regs, limb products, adder tree, result.
module iddmm_mul_pipe #(
    parameter int W     = 128,
    parameter int LIMB  = 16,
    parameter int TAG_W = 8
) (
    input logic             clk,
    input logic             rst,
    iddmm_mul_pipe_if.slave bus
);
    localparam int N   = W / LIMB;
    localparam int LAT = 3 + $clog2(N);
    localparam int LV  = $clog2(2 * N);
    localparam int P   = 1 << LV;
    localparam int PW  = 2 * LIMB;
    localparam int SW  = 2 * W + 2;
    localparam int DW  = 2 * W;

    logic                      adv;
    logic [LAT-1:0]            vld;
    logic [LAT-1:0][TAG_W-1:0] tag_p;
    logic [LAT-2:0]            low_p;
    logic [W-1:0]              x_q;
    logic [W-1:0]              y_q;
    logic [PW-1:0]             prod_q [N][N];
    logic [SW-1:0]             leaf   [P];
    logic [SW-1:0]             tree_q [LV-1][P];
    logic [DW-1:0]             sum_fin;
    logic [DW-1:0]             result_q;

    assign adv = !vld[LAT-1] || bus.out_ready;

    // Products with the same row and column parity never overlap, so each leaf is
    // a plain concatenation; 2N leaves give a tree of exactly LV levels.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            leaf[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                leaf[2*i + j%2] = leaf[2*i + j%2] | (SW'(prod_q[i][j]) << ((i + j) * LIMB));
            end
        end
    end

    // The last tree level is folded into the result register.
    assign sum_fin = DW'(tree_q[LV-2][0] + tree_q[LV-2][1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            tag_p    <= '0;
            low_p    <= '0;
            result_q <= '0;
        end else if (adv) begin
            vld   <= {vld[LAT-2:0], bus.in_valid};
            tag_p <= {tag_p[LAT-2:0], bus.in_tag};
            low_p <= {low_p[LAT-3:0], bus.mode[0]};
            if (!vld[LAT-2]) begin
                result_q <= '0;
            end else if (low_p[LAT-2]) begin
                result_q <= {{W{1'b0}}, sum_fin[W-1:0]};
            end else begin
                result_q <= sum_fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            x_q <= bus.x;
            y_q <= bus.mode[1] ? bus.x : bus.y;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    prod_q[i][j] <= PW'(x_q[i*LIMB +: LIMB]) * PW'(y_q[j*LIMB +: LIMB]);
                end
            end
            for (int k = 0; k < P/2; k++) begin
                tree_q[0][k]       <= leaf[2*k] + leaf[2*k+1];
                tree_q[0][k + P/2] <= '0;
            end
            for (int l = 1; l < LV-1; l++) begin
                for (int k = 0; k < P/2; k++) begin
                    tree_q[l][k]       <= tree_q[l-1][2*k] + tree_q[l-1][2*k+1];
                    tree_q[l][k + P/2] <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld[LAT-1];
    assign bus.out_tag   = tag_p[LAT-1];
    assign bus.result    = result_q;
    assign bus.busy      = |vld;
endmodule

// File: tb/tb_iddmm_mul_pipe.sv
// Directed and random checks of iddmm_mul_pipe at W=128 (LAT=6) and W=64 (LAT=5)
// against a plain-arithmetic product model with an in-order expectation queue.
module tb_iddmm_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iddmm_mul_pipe_if #(.W(128), .TAG_W(8)) b1 ();
    iddmm_mul_pipe_if #(.W(64),  .TAG_W(8)) b2 ();

    iddmm_mul_pipe #(.W(128), .LIMB(16), .TAG_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    iddmm_mul_pipe #(.W(64),  .LIMB(16), .TAG_W(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [255:0] res;
        logic [7:0]   tag;
        int           acc;
    } exp_t;

    exp_t         q1[$];
    exp_t         q2[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           pops1 = 0;
    int           pops2 = 0;
    bit           lat_chk = 1'b1;
    bit           acc1, acc2, ov1;
    bit           hold1 = 1'b0;
    bit           hold2 = 1'b0;
    logic [255:0] hres1, hres2, last1;
    logic [7:0]   htag1, htag2, last_tag1;

    task automatic check(string name, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [255:0] model(logic [255:0] x, logic [255:0] y, logic [1:0] m, int w);
        logic [255:0] p;
        p = m[1] ? x * x : x * y;
        if (m[0]) p = p & ((256'd1 << w) - 256'd1);
        return p;
    endfunction

    // One clock: sample both buses at the falling edge, score handshakes, then advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ov1  = b1.out_valid;
        acc1 = 1'b0;
        acc2 = 1'b0;
        if (!rst) begin
            if (hold1) begin
                check("hold_valid1", b1.out_valid, 1);
                check("hold_result1", b1.result, hres1);
                check("hold_tag1", b1.out_tag, htag1);
            end
            hold1 = b1.out_valid && !b1.out_ready;
            hres1 = b1.result;
            htag1 = b1.out_tag;
            check("in_ready1", b1.in_ready, !b1.out_valid || b1.out_ready);
            if (b1.out_valid && b1.out_ready) begin
                check("q_nonempty1", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("result1", b1.result, e.res);
                    check("tag1", b1.out_tag, e.tag);
                    if (lat_chk) check("latency1", cyc - e.acc, 6);
                    last1     = b1.result;
                    last_tag1 = b1.out_tag;
                    pops1++;
                end
            end
            if (b1.in_valid && b1.in_ready) begin
                q1.push_back('{res: model({128'b0, b1.x}, {128'b0, b1.y}, b1.mode, 128),
                               tag: b1.in_tag, acc: cyc});
                acc1 = 1'b1;
            end

            if (hold2) begin
                check("hold_valid2", b2.out_valid, 1);
                check("hold_result2", b2.result, hres2);
                check("hold_tag2", b2.out_tag, htag2);
            end
            hold2 = b2.out_valid && !b2.out_ready;
            hres2 = b2.result;
            htag2 = b2.out_tag;
            check("in_ready2", b2.in_ready, !b2.out_valid || b2.out_ready);
            if (b2.out_valid && b2.out_ready) begin
                check("q_nonempty2", q2.size() > 0, 1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    check("result2", b2.result, e.res);
                    check("tag2", b2.out_tag, e.tag);
                    if (lat_chk) check("latency2", cyc - e.acc, 5);
                    pops2++;
                end
            end
            if (b2.in_valid && b2.in_ready) begin
                q2.push_back('{res: model({192'b0, b2.x}, {192'b0, b2.y}, b2.mode, 64),
                               tag: b2.in_tag, acc: cyc});
                acc2 = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            q1.delete();
            q2.delete();
            hold1 = 1'b0;
            hold2 = 1'b0;
        end
        #1;
    endtask

    task automatic op1(logic [127:0] x, logic [127:0] y, logic [1:0] m, logic [7:0] t);
        b1.in_valid = 1'b1;
        b1.x        = x;
        b1.y        = y;
        b1.mode     = m;
        b1.in_tag   = t;
    endtask

    task automatic send1(logic [127:0] x, logic [127:0] y, logic [1:0] m, logic [7:0] t);
        op1(x, y, m, t);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc1) break;
        end
        check("send_accepted1", acc1, 1);
        b1.in_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        for (int i = 0; i < budget && (q1.size() > 0 || q2.size() > 0); i++) tick();
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q2_empty", q2.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] bx [8];
        logic [127:0] by [8];
        logic [1:0]   bm [8];
        logic [11:0]  ovs;
        logic [4:0]   pat;
        logic [127:0] ones;
        int           p0, idx, sent1, sent2;

        rst = 1'b1;
        b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.x = '0; b1.y = '0; b1.mode = '0; b1.in_tag = '0;
        b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.x = '0; b2.y = '0; b2.mode = '0; b2.in_tag = '0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_out_valid", b1.out_valid, 0);
        check("rst_result", b1.result, 0);
        check("rst_out_tag", b1.out_tag, 0);
        check("rst_busy", b1.busy, 0);
        check("rst_in_ready", b1.in_ready, 1);
        check("rst_busy2", b2.busy, 0);

        // Max operands; out_valid must last exactly one cycle
        ones = '1;
        send1(ones, ones, 2'b00, 8'h5A);
        drain(30);
        check("max_result", last1, {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1});
        check("max_tag", last_tag1, 8'h5A);
        tick();
        check("max_one_cycle", ov1, 0);

        // Mode rules
        send1(128'd1 << 127, 128'd2, 2'b00, 8'h01);
        drain(30);
        check("mode0_full", last1, 256'd1 << 128);
        send1(128'd1 << 127, 128'd2, 2'b01, 8'h02);
        drain(30);
        check("mode1_low", last1, 0);
        send1(128'd3, 128'hDEAD, 2'b10, 8'h03);
        drain(30);
        check("mode2_square", last1, 9);
        send1(128'd3, 128'hDEAD, 2'b11, 8'h04);
        drain(30);
        check("mode3_square_low", last1, 9);

        // Backpressure: 8 back-to-back ops, downstream stalled in cycles 4..13
        for (int i = 0; i < 8; i++) begin
            bx[i] = {$urandom, $urandom, $urandom, $urandom};
            by[i] = {$urandom, $urandom, $urandom, $urandom};
            bm[i] = 2'($urandom_range(0, 3));
        end
        lat_chk = 1'b0;
        p0  = pops1;
        idx = 0;
        for (int c = 0; c < 60 && (idx < 8 || q1.size() > 0); c++) begin
            b1.out_ready = !(c >= 4 && c <= 13);
            if (idx < 8) op1(bx[idx], by[idx], bm[idx], 8'(idx));
            else b1.in_valid = 1'b0;
            tick();
            if (acc1) idx++;
        end
        b1.out_ready = 1'b1;
        check("bp_all_sent", idx, 8);
        check("bp_all_out", pops1 - p0, 8);
        drain(20);
        lat_chk = 1'b1;

        // Bubbles: in_valid 1,0,1,1,0 returns the same out_valid pattern 6 cycles later
        pat = 5'b01101;
        for (int c = 0; c < 12; c++) begin
            if (c < 5 && pat[c]) op1({$urandom, $urandom, $urandom, $urandom},
                                     {$urandom, $urandom, $urandom, $urandom}, 2'b00, 8'(8'h40 + c));
            else b1.in_valid = 1'b0;
            tick();
            ovs[c] = ov1;
        end
        check("bubble_pattern", ovs, {1'b0, pat, 6'b0});
        drain(20);

        // Reset with four operations in flight
        for (int i = 0; i < 4; i++) begin
            op1({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                2'b00, 8'(8'h80 + i));
            tick();
        end
        b1.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("flush_out_valid", b1.out_valid, 0);
            check("flush_result", b1.result, 0);
            check("flush_busy", b1.busy, 0);
            tick();
        end
        send1(128'h1234_5678_9ABC_DEF0, 128'hFFFF_0000_FFFF, 2'b00, 8'hC3);
        drain(30);
        check("post_rst_result", last1, 256'h1234_5678_9ABC_DEF0 * 256'hFFFF_0000_FFFF);
        check("post_rst_tag", last_tag1, 8'hC3);

        // Random traffic on both widths with random downstream readiness
        lat_chk = 1'b0;
        sent1 = 0;
        sent2 = 0;
        p0 = pops2;
        for (int c = 0; c < 8000 && sent2 < 1000; c++) begin
            b2.in_valid  = ($urandom_range(0, 3) != 0);
            b2.x         = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            b2.y         = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            b2.mode      = 2'($urandom_range(0, 3));
            b2.in_tag    = 8'(sent2);
            b2.out_ready = ($urandom_range(0, 1) != 0);
            b1.in_valid  = ($urandom_range(0, 1) != 0);
            b1.x         = {$urandom, $urandom, $urandom, $urandom};
            b1.y         = {$urandom, $urandom, $urandom, $urandom};
            b1.mode      = 2'($urandom_range(0, 3));
            b1.in_tag    = 8'(sent1);
            b1.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (acc1) sent1++;
            if (acc2) sent2++;
        end
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        check("rand_sent2", sent2, 1000);
        drain(100);
        check("rand_out2", pops2 - p0, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
